// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, rx state encoding and tx state constants
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Transmit-side state encoding, kept here so uart_tx can share it
    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_START = 3'd1;
    localparam logic [2:0] TX_DATA  = 3'd2;
    localparam logic [2:0] TX_STOP  = 3'd3;

    function automatic logic [15:0] half_bit(input int clks_per_bit);
        return 16'(clks_per_bit / 2);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the rx pin, both flops reset to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; define UART_RX_SYNC_EN to synchronize an async Rx pin
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] debug_led
);

    localparam int          DATA_BITS = UART_DATA_BITS;
    localparam logic [15:0] HALF      = half_bit(CLKS_PER_BIT);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (Rx),
        .q   (rx_s)
    );
`else
    assign rx_s = Rx;
`endif

    rx_state_t             state, state_n;
    logic [15:0]           baud_cnt, baud_n;
    logic [2:0]            bit_idx, idx_n;
    logic [DATA_BITS-1:0]  shreg, shreg_n;
    logic [7:0]            data_n;
    logic                  valid_n, err_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_idx    <= idx_n;
            shreg      <= shreg_n;
            data       <= data_n;
            data_valid <= valid_n;
            frame_err  <= err_n;
            busy       <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        idx_n   = bit_idx;
        shreg_n = shreg;
        data_n  = data;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    idx_n = '0;
                    // With one clock per bit there is no mid-bit point to wait for
                    if (HALF == 16'd0) begin
                        state_n = DATA;
                        baud_n  = '0;
                    end else begin
                        state_n = START;
                        baud_n  = 16'd1;
                    end
                end
            end
            START: begin
                if (baud_cnt == HALF) begin
                    baud_n  = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_n           = '0;
                    shreg_n[bit_idx] = rx_s;
                    if (bit_idx == IDX_LAST) begin
                        state_n = STOP;
                    end else begin
                        idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            BREAK: begin
                // A held-low line must rise before another start bit is accepted
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
                idx_n   = '0;
            end
        endcase
    end

    assign debug_led = data;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at 1 and 16 clocks per bit
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx1 = 1'b1;
    logic       rx16 = 1'b1;
    logic [7:0] data1, data16, led1, led16;
    logic       dv1, dv16, fe1, fe16, busy1, busy16;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int viol = 0;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        bit         err;
    } ev_t;

    ev_t ev1[$];
    ev_t ev16[$];
    bit  p1 = 0;
    bit  p16 = 0;

    uart_rx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .Rx         (rx1),
        .data       (data1),
        .data_valid (dv1),
        .frame_err  (fe1),
        .busy       (busy1),
        .debug_led  (led1)
    );

    uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .Rx         (rx16),
        .data       (data16),
        .data_valid (dv16),
        .frame_err  (fe16),
        .busy       (busy16),
        .debug_led  (led16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv1)  ev1.push_back(ev_t'{cyc, data1, 1'b0});
        if (fe1)  ev1.push_back(ev_t'{cyc, data1, 1'b1});
        if (dv16) ev16.push_back(ev_t'{cyc, data16, 1'b0});
        if (fe16) ev16.push_back(ev_t'{cyc, data16, 1'b1});
        if ((dv1 && fe1) || (dv16 && fe16)) viol++;
        if (((dv1 || fe1) && p1) || ((dv16 || fe16) && p16)) viol++;
        p1  = dv1 | fe1;
        p16 = dv16 | fe16;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: stop bit is sampled 9 bit-times plus half a bit after the start edge
    function automatic int exp_edge(input int s, input int cpb);
        return s + 9 * cpb + cpb / 2 + SYNC_LAT;
    endfunction

    task automatic send(input bit wide, input logic [7:0] b, input logic stop, output int s);
        logic [9:0] f;
        int cpb;
        f   = {stop, b, 1'b0};
        cpb = wide ? 16 : 1;
        s   = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            if (wide) rx16 = f[i];
            else      rx1  = f[i];
            tick(cpb);
        end
    endtask

    task automatic check_ev(input string name, input ev_t got, input logic [7:0] d,
                            input bit err, input int at);
        checks++;
        if (got.d !== d || got.err !== err || got.cyc !== at) begin
            errors++;
            $display("FAIL %s: got data=%02h err=%0d cyc=%0d, want data=%02h err=%0d cyc=%0d",
                     name, got.d, got.err, got.cyc, d, err, at);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(3);
        checks++;
        if ({data1, dv1, fe1, busy1, led1} !== 19'd0) begin
            errors++;
            $display("FAIL reset_cpb1: got %h, want 0", {data1, dv1, fe1, busy1, led1});
        end
        checks++;
        if ({data16, dv16, fe16, busy16, led16} !== 19'd0) begin
            errors++;
            $display("FAIL reset_cpb16: got %h, want 0", {data16, dv16, fe16, busy16, led16});
        end
        rst = 1'b1;
        tick(3);
    endtask

    task automatic test_loopback;
        logic [7:0] bytes[8];
        int         starts[8];
        ev1.delete();
        bytes[0] = 8'hA5;
        for (int i = 1; i < 8; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) send(1'b0, bytes[i], 1'b1, starts[i]);
        tick(20);
        checks++;
        if (ev1.size() !== 8) begin
            errors++;
            $display("FAIL loopback_count: got %0d events, want 8", ev1.size());
        end else begin
            for (int i = 0; i < 8; i++)
                check_ev($sformatf("loopback_frame%0d", i), ev1[i], bytes[i], 1'b0,
                         exp_edge(starts[i], 1));
        end
        checks++;
        if (led1 !== bytes[7] || data1 !== bytes[7]) begin
            errors++;
            $display("FAIL loopback_hold: got data=%02h led=%02h, want %02h", data1, led1, bytes[7]);
        end
    endtask

    task automatic test_back_to_back;
        int s0, s1;
        ev16.delete();
        send(1'b1, 8'h3C, 1'b1, s0);
        send(1'b1, 8'hC3, 1'b1, s1);
        tick(40);
        checks++;
        if (ev16.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d events, want 2", ev16.size());
        end else begin
            check_ev("b2b_first", ev16[0], 8'h3C, 1'b0, exp_edge(s0, 16));
            check_ev("b2b_second", ev16[1], 8'hC3, 1'b0, exp_edge(s1, 16));
            checks++;
            if (ev16[1].cyc - ev16[0].cyc !== 160) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d cycles, want 160", ev16[1].cyc - ev16[0].cyc);
            end
        end
    endtask

    task automatic test_random_gaps;
        logic [7:0] bytes[4];
        int         starts[4];
        ev16.delete();
        for (int i = 0; i < 4; i++) begin
            bytes[i] = 8'($urandom);
            send(1'b1, bytes[i], 1'b1, starts[i]);
            tick($urandom_range(0, 20));
        end
        tick(40);
        checks++;
        if (ev16.size() !== 4) begin
            errors++;
            $display("FAIL random_count: got %0d events, want 4", ev16.size());
        end else begin
            for (int i = 0; i < 4; i++)
                check_ev($sformatf("random_frame%0d", i), ev16[i], bytes[i], 1'b0,
                         exp_edge(starts[i], 16));
        end
    endtask

    task automatic test_glitch;
        int cnt;
        ev16.delete();
        cnt  = 0;
        rx16 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) rx16 = 1'b1;
            tick(1);
            if (busy16) cnt++;
        end
        checks++;
        if (cnt < 1 || cnt > 8) begin
            errors++;
            $display("FAIL glitch_busy: got %0d busy cycles, want 1..8", cnt);
        end
        checks++;
        if (ev16.size() !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got %0d events, want 0", ev16.size());
        end
    endtask

    task automatic test_break;
        logic [7:0] prev;
        int         s0, s1, s2;
        ev16.delete();
        prev = 8'($urandom);
        send(1'b1, prev, 1'b1, s0);
        send(1'b1, 8'h55, 1'b0, s1);
        tick(50 * 16);
        checks++;
        if (ev16.size() !== 2) begin
            errors++;
            $display("FAIL break_count: got %0d events, want 2", ev16.size());
        end else begin
            check_ev("break_good", ev16[0], prev, 1'b0, exp_edge(s0, 16));
            check_ev("break_err", ev16[1], prev, 1'b1, exp_edge(s1, 16));
        end
        checks++;
        if (data16 !== prev || busy16 !== 1'b1) begin
            errors++;
            $display("FAIL break_hold: got data=%02h busy=%0d, want data=%02h busy=1",
                     data16, busy16, prev);
        end
        rx16 = 1'b1;
        tick(5);
        ev16.delete();
        send(1'b1, 8'h12, 1'b1, s2);
        tick(40);
        checks++;
        if (ev16.size() !== 1) begin
            errors++;
            $display("FAIL break_recover_count: got %0d events, want 1", ev16.size());
        end else begin
            check_ev("break_recover", ev16[0], 8'h12, 1'b0, exp_edge(s2, 16));
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        int         s;
        ev1.delete();
        ev16.delete();
        b = 8'hA7;
        for (int k = 0; k < 5 * 16 + 8; k++) begin
            rx16 = (k < 16) ? 1'b0 : b[k / 16 - 1];
            tick(1);
        end
        rst  = 1'b0;
        tick(1);
        rst  = 1'b1;
        rx16 = 1'b1;
        tick(200);
        checks++;
        if (data16 !== 8'h00 || data1 !== 8'h00 || busy16 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got data16=%02h data1=%02h busy16=%0d, want 00 00 0",
                     data16, data1, busy16);
        end
        checks++;
        if (ev16.size() !== 0 || ev1.size() !== 0) begin
            errors++;
            $display("FAIL midreset_pulses: got %0d/%0d events, want 0", ev16.size(), ev1.size());
        end
        send(1'b1, 8'hFF, 1'b1, s);
        tick(40);
        checks++;
        if (ev16.size() !== 1) begin
            errors++;
            $display("FAIL midreset_next_count: got %0d events, want 1", ev16.size());
        end else begin
            check_ev("midreset_next", ev16[0], 8'hFF, 1'b0, exp_edge(s, 16));
        end
    endtask

    task automatic test_pulse_rules;
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL pulse_rules: got %0d overlapping/extended pulses, want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_random_gaps();
        test_glitch();
        test_break();
        test_reset_mid();
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive end of the team's 8N1 UART link, counterpart to the uart_tx transmitter.
- Recovers bytes from a serial line (LSB first, one start bit, one stop bit, idle-high).
- Presents each byte with a one-cycle valid strobe; flags framing errors.
- Sits between the board RX pin (or a loopback of uart_tx Tx) and the TEA core input path.

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit; 1 matches uart_tx (one bit per clk); legal range 1..65535.
- DATA_BITS, 8, data bits per frame; fixed at 8, taken from the package.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
- Rx  input  1  serial line, idle high
- data  output  8  last correctly received byte; held until the next good frame
- data_valid  output  1  one-cycle pulse; data is new this cycle
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- busy  output  1  high in any state other than IDLE
- debug_led  output  8  mirrors data

Behaviour:
- Timing terms:
  - rx_s = Rx, or its synchronized copy (see Optional Feature).
  - M = CLKS_PER_BIT/2 (integer division).
  - baud_cnt is 16-bit; bit_idx is 3-bit.
- Reset (rst==0 at posedge):
  - state=IDLE; data=0; data_valid=0; frame_err=0; busy=0; counters=0.
  - Reset mid-frame aborts the frame silently; no pulse is generated.
- States:
  - IDLE: if rx_s==0, this cycle is the start detect. If M==0, go to DATA with baud_cnt=0. Otherwise go to START with baud_cnt=1.
  - START: baud_cnt increments each cycle. When baud_cnt==M, sample rx_s. If 1, it was a glitch: return to IDLE with no pulse. If 0, go to DATA with baud_cnt=0, bit_idx=0.
  - DATA: baud_cnt increments each cycle. When baud_cnt==CLKS_PER_BIT-1, shift rx_s into shreg[bit_idx] and reset baud_cnt=0. If bit_idx==7, go to STOP; otherwise bit_idx++.
  - STOP: when baud_cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1: data<=shreg and data_valid=1 next cycle; go to IDLE.
    - If 0: frame_err=1 next cycle; data unchanged; go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line (break) from re-triggering continuously.
- Outputs:
  - All outputs are registered.
  - data_valid and frame_err are never high together and are never high for more than one cycle.
- Latency:
  - With CLKS_PER_BIT=1 and no synchronizer, data_valid rises 10 cycles after the start-bit cycle on Rx.
  - When looped back from uart_tx, data_valid is high 11 cycles after uart_tx's data_valid was sampled.
- Back-to-back frames: a start bit beginning the cycle after the stop-bit sample is detected. Minimum gap is zero idle cycles.
- Counter wrap: baud_cnt never exceeds CLKS_PER_BIT-1 in DATA/STOP, or M in START. No overflow is possible.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: Rx passes through a two-flop synchronizer before rx_s. Both flops reset to 1. End-to-end latency increases by exactly 2 cycles. Use this for an asynchronous external pin.
- Undefined: rx_s=Rx directly. Use this for same-clock loopback from uart_tx.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_BITS=8.
  - The rx state enum (IDLE, START, DATA, STOP, BREAK; 3-bit).
  - The tx state constants, to be shared with uart_tx later.
- Sub-module uart_rx_sync: a parameterless two-flop synchronizer with reset value 1. It is instantiated only under UART_RX_SYNC_EN.

Test Plan:
- Loopback, CLKS_PER_BIT=1, no sync. uart_tx sends 0xA5 → one data_valid pulse, data=0xA5, frame_err never high, 11 cycles after tx data_valid.
- CLKS_PER_BIT=16. Drive frame 0x3C, then frame 0xC3 with zero idle between → two data_valid pulses 160 cycles apart, data=0x3C then 0xC3.
- CLKS_PER_BIT=16. Rx low for 3 cycles, then high → returns to IDLE; no data_valid or frame_err; busy high for ≤8 cycles.
- Frame 0x55 with stop bit driven 0, Rx then held low for 50 bit-times → exactly one frame_err pulse, data keeps its previous value, no further pulses until Rx goes high; the next good frame 0x12 is received.
- rst=0 asserted during bit 4 of a frame, released one cycle later → data=0, no pulse; the following frame 0xFF is received correctly.
- UART_RX_SYNC_EN defined, repeat scenario 1 → same data; data_valid arrives exactly 2 cycles later.
